// File: rtl/agc_sched.sv
// agc_sched: round-robin automatic gain control for three RF channels.
// Each window counts magnitude hits on one channel's quantizer output and
// nudges that channel's 10-bit gain toward the programmed target band.
// Optional build macro AGC_FAST_ATTACK_EN: large errors step by 4*STEP.
module agc_sched #(
   parameter int DWELL_LOG2 = 16,
   parameter int STEP       = 4,
   parameter int PWM_INIT   = 512,
   parameter int PWM_MIN    = 0,
   parameter int PWM_MAX    = 1023
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        enable,
   input  logic        sample_en,
   input  logic [5:0]  si,
   input  logic [7:0]  target,
   input  logic [7:0]  hyst,
   input  logic        load,
   input  logic [1:0]  load_ch,
   input  logic [9:0]  load_val,
   output logic [9:0]  pwm_ch1,
   output logic [9:0]  pwm_ch2,
   output logic [9:0]  pwm_ch3,
   output logic [1:0]  cur_ch,
   output logic        update,
   output logic [7:0]  last_frac,
   output logic [2:0]  locked
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCUM  = 2'd1;
   localparam logic [1:0] S_DECIDE = 2'd2;
   localparam logic [1:0] S_APPLY  = 2'd3;

   localparam int                SHIFT   = DWELL_LOG2 - 8;
   localparam logic signed [11:0] MIN_S  = 12'(PWM_MIN);
   localparam logic signed [11:0] MAX_S  = 12'(PWM_MAX);
   localparam logic signed [11:0] STEP_S = 12'(STEP);
   localparam logic [9:0]        INIT_V  = 10'(PWM_INIT);

   // Gain arithmetic is done wide and signed, then clamped into range.
   function automatic logic [9:0] clamp_gain(input logic signed [11:0] v);
      if (v < MIN_S)      return MIN_S[9:0];
      else if (v > MAX_S) return MAX_S[9:0];
      else                return v[9:0];
   endfunction

   logic [1:0]              state_q, state_d;
   logic [DWELL_LOG2-1:0]   win_q, win_d;
   logic [DWELL_LOG2:0]     mag_q, mag_d;
   logic [2:0][9:0]         pwm_q, pwm_d;
   logic [1:0]              cur_q, cur_d;
   logic                    upd_q, upd_d;
   logic [7:0]              frac_q, frac_d;
   logic [2:0]              lock_q, lock_d;
   logic [7:0]              dfrac_q, dfrac_d;
   logic signed [11:0]      delta_q, delta_d;
   logic                    dlock_q, dlock_d;

   logic                    mag_bit;
   logic [9:0]              cur_pwm;
   logic [DWELL_LOG2:0]     mag_sh;
   logic [7:0]              frac_c;
   logic [8:0]              hi_c;
   logic [7:0]              lo_c;
   logic                    has_lo, dn_c, up_c;
   logic signed [11:0]      step_c, delta_c;
`ifdef AGC_FAST_ATTACK_EN
   logic [9:0]              h3_c;
   logic [10:0]             hi_f;
   logic                    fast_dn, fast_up;
`endif

   // Select the measured channel's magnitude bit and current gain.
   always_comb begin
      mag_bit = si[0];
      cur_pwm = pwm_q[2];
      case (cur_q)
         2'd0:    begin mag_bit = si[4]; cur_pwm = pwm_q[0]; end
         2'd1:    begin mag_bit = si[2]; cur_pwm = pwm_q[1]; end
         default: begin mag_bit = si[0]; cur_pwm = pwm_q[2]; end
      endcase
   end

   // Window decision: fraction vs. target band, producing a signed gain delta.
   always_comb begin
      mag_sh = mag_q >> SHIFT;
      frac_c = (mag_sh > (DWELL_LOG2+1)'(255)) ? 8'hff : mag_sh[7:0];
      hi_c   = {1'b0, target} + {1'b0, hyst};
      has_lo = (target >= hyst);
      lo_c   = target - hyst;
      dn_c   = ({1'b0, frac_c} > hi_c);
      up_c   = has_lo && (frac_c < lo_c);
      step_c = STEP_S;
`ifdef AGC_FAST_ATTACK_EN
      // Outer band sits 3*hyst beyond the dead band; a full 8-bit frac can
      // never exceed an upper bound that saturates at 255.
      h3_c    = 10'(hyst) * 10'd3;
      hi_f    = {2'b00, hi_c} + {1'b0, h3_c};
      fast_dn = ({3'b000, frac_c} > hi_f);
      fast_up = has_lo && (h3_c <= {2'b00, lo_c}) &&
                ({2'b00, frac_c} < ({2'b00, lo_c} - h3_c));
      if ((dn_c && fast_dn) || (up_c && fast_up))
         step_c = STEP_S <<< 2;
`endif
      if (dn_c)      delta_c = -step_c;
      else if (up_c) delta_c = step_c;
      else           delta_c = '0;
   end

   // Next-state: FSM, window counters, gain/lock update and CPU force.
   always_comb begin
      state_d = state_q;
      win_d   = win_q;
      mag_d   = mag_q;
      pwm_d   = pwm_q;
      cur_d   = cur_q;
      upd_d   = 1'b0;
      frac_d  = frac_q;
      lock_d  = lock_q;
      dfrac_d = dfrac_q;
      delta_d = delta_q;
      dlock_d = dlock_q;
      case (state_q)
         S_IDLE: if (enable) state_d = S_ACCUM;
         S_ACCUM: begin
            if (!enable) begin
               state_d = S_IDLE;
               win_d   = '0;
               mag_d   = '0;
            end else if (sample_en) begin
               win_d = win_q + 1'b1;
               mag_d = mag_q + (DWELL_LOG2+1)'(mag_bit);
               if (win_q == '1) state_d = S_DECIDE;
            end
         end
         S_DECIDE: begin
            dfrac_d = frac_c;
            delta_d = delta_c;
            dlock_d = (delta_c == '0);
            state_d = S_APPLY;
         end
         default: begin
            case (cur_q)
               2'd0:    begin pwm_d[0] = clamp_gain($signed({2'b00, cur_pwm}) + delta_q); lock_d[0] = dlock_q; end
               2'd1:    begin pwm_d[1] = clamp_gain($signed({2'b00, cur_pwm}) + delta_q); lock_d[1] = dlock_q; end
               default: begin pwm_d[2] = clamp_gain($signed({2'b00, cur_pwm}) + delta_q); lock_d[2] = dlock_q; end
            endcase
            frac_d  = dfrac_q;
            upd_d   = 1'b1;
            cur_d   = (cur_q == 2'd2) ? 2'd0 : cur_q + 2'd1;
            win_d   = '0;
            mag_d   = '0;
            state_d = enable ? S_ACCUM : S_IDLE;
         end
      endcase
      // CPU force overrides any same-cycle window write on that channel.
      if (load) begin
         case (load_ch)
            2'd0:    pwm_d[0] = clamp_gain($signed({2'b00, load_val}));
            2'd1:    pwm_d[1] = clamp_gain($signed({2'b00, load_val}));
            2'd2:    pwm_d[2] = clamp_gain($signed({2'b00, load_val}));
            default: ;
         endcase
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         win_q   <= '0;
         mag_q   <= '0;
         pwm_q   <= {3{INIT_V}};
         cur_q   <= 2'd0;
         upd_q   <= 1'b0;
         frac_q  <= 8'd0;
         lock_q  <= 3'b000;
         dfrac_q <= 8'd0;
         delta_q <= '0;
         dlock_q <= 1'b0;
      end else begin
         state_q <= state_d;
         win_q   <= win_d;
         mag_q   <= mag_d;
         pwm_q   <= pwm_d;
         cur_q   <= cur_d;
         upd_q   <= upd_d;
         frac_q  <= frac_d;
         lock_q  <= lock_d;
         dfrac_q <= dfrac_d;
         delta_q <= delta_d;
         dlock_q <= dlock_d;
      end
   end

   assign pwm_ch1   = pwm_q[0];
   assign pwm_ch2   = pwm_q[1];
   assign pwm_ch3   = pwm_q[2];
   assign cur_ch    = cur_q;
   assign update    = upd_q;
   assign last_frac = frac_q;
   assign locked    = lock_q;

endmodule

// File: tb/tb_agc_sched.sv
// Bench for agc_sched with an 8-bit dwell: random per-window data and gaps,
// checked against a window-level arithmetic reference model.
module tb_agc_sched;

   localparam int DW   = 8;
   localparam int WIN  = 1 << DW;
   localparam int STEP = 4;

   logic       clk = 1'b0;
   logic       reset_n, enable, sample_en, load;
   logic [5:0] si;
   logic [7:0] target, hyst;
   logic [1:0] load_ch;
   logic [9:0] load_val;
   logic [9:0] pwm_ch1, pwm_ch2, pwm_ch3;
   logic [1:0] cur_ch;
   logic       update;
   logic [7:0] last_frac;
   logic [2:0] locked;

   int         total = 0;
   int         bad   = 0;
   int         exp_pwm [3];
   int         exp_cur;
   int         exp_frac;
   logic [2:0] exp_locked;
   bit         ab_early;

   agc_sched #(.DWELL_LOG2(DW), .STEP(STEP), .PWM_INIT(512), .PWM_MIN(0), .PWM_MAX(1023)) dut (
      .clk(clk), .reset_n(reset_n), .enable(enable), .sample_en(sample_en), .si(si),
      .target(target), .hyst(hyst), .load(load), .load_ch(load_ch), .load_val(load_val),
      .pwm_ch1(pwm_ch1), .pwm_ch2(pwm_ch2), .pwm_ch3(pwm_ch3), .cur_ch(cur_ch),
      .update(update), .last_frac(last_frac), .locked(locked)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
      total++;
      assert (got === expv) else begin
         bad++;
         $error("FAIL %s: got %0d expected %0d", tag, got, expv);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, " pwm_ch1"}, 32'(pwm_ch1), exp_pwm[0]);
      chk({tag, " pwm_ch2"}, 32'(pwm_ch2), exp_pwm[1]);
      chk({tag, " pwm_ch3"}, 32'(pwm_ch3), exp_pwm[2]);
      chk({tag, " cur_ch"}, 32'(cur_ch), exp_cur);
      chk({tag, " locked"}, 32'(locked), 32'(exp_locked));
      chk({tag, " last_frac"}, 32'(last_frac), exp_frac);
   endtask

   task automatic set_reset_exp;
      for (int i = 0; i < 3; i++) exp_pwm[i] = 512;
      exp_cur = 0; exp_frac = 0; exp_locked = 3'b000;
   endtask

   // Gain after one window: band test on the measured fraction, then clamp.
   function automatic int ref_gain(input int g, input int frac, input int t, input int h, output bit lk);
      int st, r;
      st = STEP; r = g; lk = 1'b0;
      if (frac > t + h) begin
`ifdef AGC_FAST_ATTACK_EN
         if (frac > ((t + 4*h > 255) ? 255 : t + 4*h)) st = 4*STEP;
`endif
         r = g - st;
      end else if (t >= h && frac < t - h) begin
`ifdef AGC_FAST_ATTACK_EN
         if (t - 4*h >= 0 && frac < t - 4*h) st = 4*STEP;
`endif
         r = g + st;
      end else begin
         lk = 1'b1;
      end
      if (r < 0) r = 0;
      if (r > 1023) r = 1023;
      return r;
   endfunction

   // One full window on the expected channel. pat: 0 all ones, 1 every third,
   // 2 all zeros, 3 random with pct% density. Other channels carry noise.
   task automatic run_window(input int pat, input int pct, input bit do_load);
      int n, mag, ch, frac, g;
      bit early, b, lk;
      logic [5:0] s;
      ch = exp_cur; n = 0; mag = 0; early = 1'b0;
      while (n < WIN) begin
         sample_en = ($urandom_range(0, 4) != 0);
         s = 6'($urandom);
         case (pat)
            0:       b = 1'b1;
            1:       b = (n % 3 == 0);
            2:       b = 1'b0;
            default: b = ($urandom_range(0, 99) < pct);
         endcase
         s[4 - 2*ch] = b;
         si = s;
         tick;
         if (update !== 1'b0) early = 1'b1;
         if (sample_en) begin
            mag += int'(b);
            n++;
         end
      end
      chk("no early update", 32'(early), 0);
      sample_en = 1'b1; si = 6'($urandom);
      tick;
      chk("update after decide", 32'(update), 0);
      if (do_load) begin
         load = 1'b1; load_ch = 2'(ch); load_val = 10'd300;
      end
      tick;
      chk("update after apply", 32'(update), 1);
      load = 1'b0; sample_en = 1'b0;
      frac = mag >> (DW - 8);
      if (frac > 255) frac = 255;
      g = ref_gain(exp_pwm[ch], frac, int'(target), int'(hyst), lk);
      exp_pwm[ch]    = do_load ? 300 : g;
      exp_locked[ch] = lk;
      exp_frac       = frac;
      exp_cur        = (ch + 1) % 3;
      check_all("window");
      tick;
      chk("update width", 32'(update), 0);
   endtask

   initial begin
      reset_n = 1'b0; enable = 1'b0; sample_en = 1'b0; si = '0;
      target = 8'd85; hyst = 8'd10; load = 1'b0; load_ch = '0; load_val = '0;
      set_reset_exp();
      tick; tick;
      check_all("reset");
      chk("reset update", 32'(update), 0);
      reset_n = 1'b1;
      tick;

      // Start loop: first enabled cycle is the IDLE->ACCUM hop.
      enable = 1'b1;
      tick;
      run_window(0, 0, 1'b0);
      run_window(1, 0, 1'b0);
      run_window(2, 0, 1'b0);

      // Force ch1 near the top, then drive it into the upper clamp.
      load = 1'b1; load_ch = 2'd0; load_val = 10'd1022;
      tick;
      load = 1'b0;
      exp_pwm[0] = 1022;
      check_all("load ch1");
      run_window(2, 0, 1'b0);
      for (int k = 0; k < 2; k++) begin
         target = 8'($urandom_range(20, 230));
         hyst   = 8'($urandom_range(0, 40));
         run_window(3, $urandom_range(0, 100), 1'b0);
      end
      target = 8'd85; hyst = 8'd10;
      run_window(2, 0, 1'b0);

      // Channel 3 in load_ch is not a channel.
      load = 1'b1; load_ch = 2'd3; load_val = 10'd1023;
      tick;
      load = 1'b0;
      check_all("load ch3 ignored");

      // Abort a ch2 window after 100 hot samples.
      ab_early = 1'b0;
      for (int i = 0; i < 100; i++) begin
         sample_en = 1'b1; si = 6'($urandom) | 6'b000100;
         tick;
         if (update !== 1'b0) ab_early = 1'b1;
      end
      enable = 1'b0;
      tick;
      if (update !== 1'b0) ab_early = 1'b1;
      chk("abort no update", 32'(ab_early), 0);
      check_all("abort");

      // Force while idle; samples while idle are ignored.
      load = 1'b1; load_ch = 2'd2; load_val = 10'd7;
      tick;
      load = 1'b0;
      exp_pwm[2] = 7;
      check_all("idle load");
      for (int i = 0; i < 5; i++) begin
         sample_en = 1'b1; si = 6'b111111;
         tick;
      end
      sample_en = 1'b0; enable = 1'b1;
      tick;
      run_window(2, 0, 1'b0);

      // Target below hysteresis: no lower bound, zero fraction stays locked.
      target = 8'd5; hyst = 8'd10;
      run_window(2, 0, 1'b0);
      target = 8'd85; hyst = 8'd10;

      // CPU force collides with the ch1 window write.
      run_window(1, 0, 1'b1);

      // Reset in the middle of a window.
      for (int i = 0; i < 50; i++) begin
         sample_en = 1'b1; si = 6'($urandom);
         tick;
      end
      reset_n = 1'b0;
      tick;
      set_reset_exp();
      check_all("mid reset");
      chk("mid reset update", 32'(update), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
